// File: rtl/red_detect_pkg.sv
// Shared definitions for the red span extraction path.
//   COORD_W         width of a column coordinate
//   NO_HIT_DEFAULT  coordinate value published for a frame with no qualified run
//   COORD_MAX       starting value of the per-frame leftmost-column accumulator
//   state_t         scan control states
package red_detect_pkg;

    localparam int unsigned COORD_W = 10;

    localparam logic [COORD_W-1:0] NO_HIT_DEFAULT = '0;
    localparam logic [COORD_W-1:0] COORD_MAX      = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

endpackage

// File: rtl/red_span_extractor_if.sv
// Pixel-stream and result bundle of red_span_extractor.
//   frame_start, line_start  one-cycle frame / line markers
//   pix_valid, pix_red       pixel qualifier and red classification
//   Data_out_A, Data_out_B   leftmost / rightmost qualified red column
//   found, coord_valid       frame had a hit / one-cycle publish strobe
// master: pixel source and result consumer; slave: the extractor.
interface red_span_extractor_if;
    import red_detect_pkg::*;

    logic               frame_start;
    logic               line_start;
    logic               pix_valid;
    logic               pix_red;
    logic [COORD_W-1:0] Data_out_A;
    logic [COORD_W-1:0] Data_out_B;
    logic               found;
    logic               coord_valid;

    modport master (
        output frame_start, line_start, pix_valid, pix_red,
        input  Data_out_A, Data_out_B, found, coord_valid
    );

    modport slave (
        input  frame_start, line_start, pix_valid, pix_red,
        output Data_out_A, Data_out_B, found, coord_valid
    );

endinterface

// File: rtl/red_run_filter.sv
// Consecutive-red run counter.
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       start of line or frame; the current pixel begins a new run
//   pix_valid   pixel present this cycle (counter holds otherwise)
//   pix_red     pixel classified red
//   qualify     this pixel is the MIN_RUN-th consecutive red pixel
//   run_cont    this pixel extends an already qualified run
module red_run_filter #(
    parameter int unsigned MIN_RUN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic pix_valid,
    input  logic pix_red,
    output logic qualify,
    output logic run_cont
);

    localparam logic [3:0] RUN_SAT = 4'(MIN_RUN);

    logic [3:0] run_q;
    logic [3:0] run_d;
    logic [3:0] run_cur;

    always_comb begin
        // A clear applies to the pixel in the same cycle, so runs never span lines.
        run_cur  = clear ? '0 : run_q;
        run_d    = run_cur;
        qualify  = 1'b0;
        run_cont = 1'b0;
        if (pix_valid) begin
            if (pix_red) begin
                if (run_cur == RUN_SAT) begin
                    run_cont = 1'b1;
                end else begin
                    run_d   = run_cur + 4'd1;
                    qualify = (run_cur == RUN_SAT - 4'd1);
                end
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

endmodule

// File: rtl/red_span_extractor.sv
// Reduces a frame's red-pixel stream to the leftmost and rightmost columns of
// qualified red runs, published once per frame on the next frame_start.
//   CLK, RST_N  clock, asynchronous active-low reset
//   bus         slave side of red_span_extractor_if (pixel stream in, results out)
module red_span_extractor
    import red_detect_pkg::*;
#(
    parameter int unsigned        H_ACTIVE = 640,
    parameter int unsigned        MIN_RUN  = 4,
    parameter logic [COORD_W-1:0] NO_HIT   = NO_HIT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    red_span_extractor_if.slave  bus
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] RUN_M1 = COORD_W'(MIN_RUN - 1);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, x_cur;
    logic [COORD_W-1:0] min_q, min_d, min_base, run_left;
    logic [COORD_W-1:0] max_q, max_d, max_base;
    logic               hit_q, hit_d, hit_base;
    logic [COORD_W-1:0] a_q, a_d;
    logic [COORD_W-1:0] b_q, b_d;
    logic               found_q, found_d;
    logic               cv_q, cv_d;
    logic               clear;
    logic               qualify;
    logic               run_cont;

    assign clear = bus.frame_start | bus.line_start;

    red_run_filter #(
        .MIN_RUN (MIN_RUN)
    ) u_run_filter (
        .clk       (CLK),
        .rst_n     (RST_N),
        .clear     (clear),
        .pix_valid (bus.pix_valid),
        .pix_red   (bus.pix_red),
        .qualify   (qualify),
        .run_cont  (run_cont)
    );

    always_comb begin
        state_d = bus.frame_start ? SCAN : state_q;

        x_cur = clear ? '0 : x_q;
        x_d   = x_cur;
        if (bus.pix_valid && (x_cur != X_LAST)) begin
            x_d = x_cur + COORD_W'(1);
        end

        // A pixel in the frame_start cycle already belongs to the new frame,
        // so it accumulates onto freshly initialised values.
        min_base = bus.frame_start ? COORD_MAX : min_q;
        max_base = bus.frame_start ? '0        : max_q;
        hit_base = bus.frame_start ? 1'b0      : hit_q;
        min_d    = min_base;
        max_d    = max_base;
        hit_d    = hit_base;
        run_left = x_cur - RUN_M1;
        if ((state_q == SCAN) || bus.frame_start) begin
            if (qualify) begin
                hit_d = 1'b1;
                if (run_left < min_base) begin
                    min_d = run_left;
                end
            end
            if ((qualify || run_cont) && (x_cur > max_base)) begin
                max_d = x_cur;
            end
        end

        // The latch uses the pre-edge accumulators of the completed frame.
        cv_d    = bus.frame_start && (state_q == SCAN);
        a_d     = a_q;
        b_d     = b_q;
        found_d = found_q;
        if (cv_d) begin
            a_d     = hit_q ? min_q : NO_HIT;
            b_d     = hit_q ? max_q : NO_HIT;
            found_d = hit_q;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            x_q     <= '0;
            min_q   <= '0;
            max_q   <= '0;
            hit_q   <= 1'b0;
            a_q     <= NO_HIT;
            b_q     <= NO_HIT;
            found_q <= 1'b0;
            cv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            min_q   <= min_d;
            max_q   <= max_d;
            hit_q   <= hit_d;
            a_q     <= a_d;
            b_q     <= b_d;
            found_q <= found_d;
            cv_q    <= cv_d;
        end
    end

    assign bus.Data_out_A  = a_q;
    assign bus.Data_out_B  = b_q;
    assign bus.found       = found_q;
    assign bus.coord_valid = cv_q;

endmodule

// File: tb/tb_red_span_extractor.sv
module tb_red_span_extractor;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;

    red_span_extractor_if bus ();

    red_span_extractor #(
        .H_ACTIVE (640),
        .MIN_RUN  (4),
        .NO_HIT   (10'd0)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_in();
        bus.frame_start = 1'b0;
        bus.line_start  = 1'b0;
        bus.pix_valid   = 1'b0;
        bus.pix_red     = 1'b0;
    endtask

    task automatic pix(input logic red, input logic ls);
        bus.line_start = ls;
        bus.pix_valid  = 1'b1;
        bus.pix_red    = red;
        tick();
        idle_in();
    endtask

    task automatic gap();
        idle_in();
        tick();
    endtask

    // One line of ncols pixels; pixel index c is red when lo <= c <= hi.
    task automatic send_line(input int ncols, input int lo, input int hi);
        for (int c = 0; c < ncols; c++) begin
            pix((c >= lo) && (c <= hi), c == 0);
        end
        gap();
    endtask

    task automatic frame_pulse();
        bus.frame_start = 1'b1;
        tick();
        idle_in();
    endtask

    task automatic chk_pub(input string tag, input int a, input int b, input int f);
        chk({tag, "_cv"}, bus.coord_valid, 1);
        chk({tag, "_A"}, bus.Data_out_A, a);
        chk({tag, "_B"}, bus.Data_out_B, b);
        chk({tag, "_found"}, bus.found, f);
        tick();
        chk({tag, "_cv_off"}, bus.coord_valid, 0);
    endtask

    initial begin
        idle_in();
        #12;
        chk("rst_A", bus.Data_out_A, 0);
        chk("rst_B", bus.Data_out_B, 0);
        chk("rst_found", bus.found, 0);
        chk("rst_cv", bus.coord_valid, 0);
        RST_N = 1'b1;
        tick();

        // Single 20-pixel run on line 5
        frame_pulse();
        chk("first_fs_cv", bus.coord_valid, 0);
        for (int l = 0; l < 5; l++) send_line(10, -1, -1);
        send_line(130, 100, 119);
        frame_pulse();
        chk_pub("t1", 100, 119, 1);

        // Run too short to qualify
        send_line(200, 50, 52);
        frame_pulse();
        chk_pub("t2", 0, 0, 0);

        // Two runs, second one pushed past the last column (saturation, no wrap)
        send_line(30, 10, 20);
        for (int l = 0; l < 7; l++) send_line(10, -1, -1);
        send_line(700, 600, 699);
        frame_pulse();
        chk_pub("t3", 10, 639, 1);

        // Run with pix_valid gaps, then a 2-pixel run
        pix(1'b0, 1'b1);
        for (int c = 1; c < 200; c++) pix(1'b0, 1'b0);
        pix(1'b1, 1'b0);
        gap(); gap();
        pix(1'b1, 1'b0);
        gap();
        pix(1'b1, 1'b0);
        pix(1'b1, 1'b0);
        for (int c = 204; c < 500; c++) pix(1'b0, 1'b0);
        pix(1'b1, 1'b0);
        pix(1'b1, 1'b0);
        pix(1'b0, 1'b0);
        gap();

        // frame_start coincident with a red pixel at x = 0
        bus.frame_start = 1'b1;
        bus.pix_valid   = 1'b1;
        bus.pix_red     = 1'b1;
        tick();
        idle_in();
        chk("t4_cv", bus.coord_valid, 1);
        chk("t4_A", bus.Data_out_A, 200);
        chk("t4_B", bus.Data_out_B, 203);
        chk("t4_found", bus.found, 1);
        pix(1'b1, 1'b0);
        chk("t4_cv_off", bus.coord_valid, 0);
        pix(1'b1, 1'b0);
        pix(1'b1, 1'b0);
        pix(1'b0, 1'b0);
        frame_pulse();
        chk_pub("t5", 0, 3, 1);

        // Reset in the middle of a run
        pix(1'b1, 1'b1);
        pix(1'b1, 1'b0);
        pix(1'b1, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        chk("mid_rst_A", bus.Data_out_A, 0);
        chk("mid_rst_B", bus.Data_out_B, 0);
        chk("mid_rst_found", bus.found, 0);
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        send_line(20, 5, 9);
        frame_pulse();
        chk("post_rst_fs1_cv", bus.coord_valid, 0);
        chk("post_rst_fs1_found", bus.found, 0);
        send_line(20, 5, 9);
        frame_pulse();
        chk_pub("t6", 5, 9, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/red_span_extractor.md
Name: red_span_extractor

Overview:
Scans the per-pixel red-classification stream of each video frame and reduces it to two 10-bit column coordinates: the leftmost and rightmost columns of qualified red runs in that frame.
- Sits upstream of the red_detect comparator and produces the pair it consumes on Data_in_A and Data_in_B.
- A run is qualified only when it is at least MIN_RUN consecutive red pixels long, which rejects single-pixel noise.
- Results are published once per frame, on the frame boundary, with a one-cycle valid strobe.

Parameters:
H_ACTIVE, 640, active pixels per line; the column counter saturates at H_ACTIVE-1.
MIN_RUN, 4, consecutive red pixels needed to qualify a run; legal range 1..15.
NO_HIT, 0, value driven on both coordinate outputs when a frame has no qualified run.

Ports:
CLK  in  1  system clock, all logic on the rising edge
RST_N  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse marking the first pixel slot of a frame
line_start  in  1  one-cycle pulse marking the first pixel slot of a line
pix_valid  in  1  pix_red is meaningful this cycle
pix_red  in  1  pixel classified red
Data_out_A  out  10  leftmost qualified red column of the last completed frame
Data_out_B  out  10  rightmost qualified red column of the last completed frame
found  out  1  last completed frame contained at least one qualified run
coord_valid  out  1  one-cycle strobe; outputs were updated this cycle

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values: Data_out_A = NO_HIT, Data_out_B = NO_HIT, found = 0, coord_valid = 0, state = IDLE, all counters and accumulators = 0.
- State machine:
  - IDLE: pixels are ignored. On frame_start, go to SCAN. No publish occurs, because no frame has completed.
  - SCAN: accumulate. On frame_start, latch the results, clear the accumulators, stay in SCAN.
  - PUBLISH: not a separate state. coord_valid is a registered pulse asserted in the cycle after the frame_start edge.
- Column counter x (10 bits):
  - Cleared to 0 on line_start or frame_start.
  - Otherwise increments after each pix_valid cycle.
  - Saturates at H_ACTIVE-1; it never wraps.
  - A pixel in a line_start or frame_start cycle has x = 0.
- Run counter (4 bits):
  - Increments on pix_valid && pix_red.
  - Cleared on pix_valid && !pix_red, line_start, or frame_start; a run never spans lines.
  - Saturates at MIN_RUN.
  - Cycles with pix_valid = 0 hold both counters.
- Qualification:
  - When the run counter reaches MIN_RUN on the current pixel, min_x = min(min_x, x-(MIN_RUN-1)).
  - On that pixel and every further red pixel of the same run, max_x = max(max_x, x).
  - hit_seen is set on qualification.
- Accumulator init per frame: min_x = 1023, max_x = 0, hit_seen = 0.
- Latch at a frame_start in SCAN:
  - If hit_seen: Data_out_A = min_x, Data_out_B = max_x, found = 1.
  - Otherwise: both coordinates = NO_HIT, found = 0.
  - Outputs hold until the next latch.
- Simultaneous events:
  - frame_start with pix_valid in the same cycle: the pixel belongs to the new frame, at x = 0.
  - The latch uses the accumulator values from before that edge.
- Latency: outputs are visible one cycle after the frame_start edge.
- Ordering guarantee: Data_out_A ≤ Data_out_B whenever found = 1.
- Reset mid-frame: partial data is discarded and the block returns to IDLE. The first frame_start after reset does not pulse coord_valid.

Decomposition:
- Shared package red_detect_pkg:
  - COORD_W = 10
  - NO_HIT default
  - state enum {IDLE, SCAN}
  - COORD_MAX = 1023 (accumulator init)
- Sub-module red_run_filter: holds the run counter and emits a qualify pulse plus a run-continuing flag. The top level owns x, the accumulators, the FSM and the output registers.

Test Plan:
- Reset, frame_start, red pixels x = 100..119 on line 5, frame_start → coord_valid high for exactly 1 cycle; Data_out_A = 100, Data_out_B = 119, found = 1.
- Only a 3-pixel red run x = 50..52 (MIN_RUN = 4), frame_start → found = 0, both outputs 0, coord_valid pulses once.
- Run x = 10..20 on line 1 and run x = 600..639 on line 9 → A = 10, B = 639. Also drive pix_valid past column 639 and check the counter saturates with no wrap to 0.
- Run x = 200..203 with pix_valid gaps inside the run, then a 2-pixel run at x = 500 → A = 200, B = 203. The gaps must not break the run.
- frame_start coincident with a red pixel at x = 0, followed by reds x = 1..3, then frame_start → the earlier frame publishes its own values; the next publish gives A = 0, B = 3, found = 1.
- RST_N low mid-run, then released → outputs return to 0 and found = 0 immediately. The first frame_start after release gives no coord_valid; the second one does.
